// File: rtl/circuit_eval_pkg.sv
// Shared types and sizing helpers for the circuit fitness evaluator.
package circuit_eval_pkg;

  localparam int MAX_N_IN = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_FINISH
  } eval_state_t;

  function automatic int fit_width(input int n_in, input int n_out);
    return $clog2((2 ** n_in) * n_out + 1);
  endfunction

endpackage

// File: rtl/circuit_evaluator_settle_timer.sv
// Loadable down-counter that times how long a vector is held before sampling.
module settle_timer #(
  parameter int SETTLE = 4,
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(SETTLE);
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Flags the final hold cycle so the owner leaves on the same edge the count runs out.
  assign expired = (r_cnt <= CW'(1));

endmodule

// File: rtl/circuit_evaluator.sv
// Sweeps all input vectors onto the evolved array and counts output bits matching a target table.
// Optional CIRCUIT_EVAL_STABILITY_CHECK_EN adds a double sample per vector and an oscillation counter.
module circuit_evaluator
  import circuit_eval_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 4,
  localparam int N_VEC = 2 ** N_IN,
  localparam int FIT_W = fit_width(N_IN, N_OUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_VEC*N_OUT-1:0] target,
  output logic [N_IN-1:0]        circ_in,
  input  logic [N_OUT-1:0]       circ_out,
  output logic                   busy,
  output logic                   done,
  output logic [FIT_W-1:0]       fitness
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
  ,
  output logic [N_IN:0]          osc_count
`endif
);

  localparam int MAX_FIT = N_VEC * N_OUT;

  eval_state_t              r_state;
  logic [N_VEC*N_OUT-1:0]   r_target;
  logic [N_IN-1:0]          r_vec;
  logic                     r_busy;
  logic                     r_done;
  logic [FIT_W-1:0]         r_fit;
  logic                     w_load;
  logic                     w_en;
  logic                     w_expired;
  logic                     w_last;
  logic                     w_sample_last;
  logic [N_OUT-1:0]         w_tslice;
  logic [N_OUT-1:0]         w_match;

  function automatic logic [FIT_W-1:0] popcount(input logic [N_OUT-1:0] b);
    logic [FIT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_OUT; i++) n = n + FIT_W'(b[i]);
    return n;
  endfunction

  function automatic logic [FIT_W-1:0] sat_add(input logic [FIT_W-1:0] a,
                                               input logic [FIT_W-1:0] b);
    logic [FIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > (FIT_W + 1)'(MAX_FIT)) return FIT_W'(MAX_FIT);
    return s[FIT_W-1:0];
  endfunction

  always_comb begin
    w_tslice = '0;
    for (int v = 0; v < N_VEC; v++)
      if (r_vec == N_IN'(v)) w_tslice = r_target[v*N_OUT +: N_OUT];
  end

  assign w_last = (r_vec == N_IN'(N_VEC - 1));
  assign w_load = ((r_state == ST_IDLE) && start) || (r_state == ST_SAMPLE);
  assign w_en   = (r_state == ST_DRIVE);

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (w_en),
    .expired (w_expired)
  );

`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
  logic             r_phase;
  logic [N_OUT-1:0] r_cap;
  logic [N_IN:0]    r_osc;
  logic             w_osc;

  // Only bits that held still across both captures may score.
  assign w_match       = ~(circ_out ^ w_tslice) & ~(circ_out ^ r_cap);
  assign w_osc         = |(circ_out ^ r_cap);
  assign w_sample_last = r_phase;
  assign osc_count     = r_osc;

  always_ff @(posedge clk) begin
    if ((r_state == ST_SAMPLE) && !r_phase) r_cap <= circ_out;
  end
`else
  assign w_match       = ~(circ_out ^ w_tslice);
  assign w_sample_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && start) r_target <= target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fit   <= '0;
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
      r_phase <= 1'b0;
      r_osc   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fit   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_DRIVE;
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
            r_phase <= 1'b0;
            r_osc   <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_fit   <= '0;
            r_vec   <= '0;
          end else if (w_expired) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Abort outranks the accumulate landing in the same cycle.
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_fit   <= '0;
            r_vec   <= '0;
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
            r_phase <= 1'b0;
`endif
          end else if (!w_sample_last) begin
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
            r_phase <= 1'b1;
`endif
          end else begin
            r_fit <= sat_add(r_fit, popcount(w_match));
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
            r_phase <= 1'b0;
            if (w_osc) r_osc <= r_osc + 1'b1;
`endif
            if (w_last) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_vec   <= '0;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_state <= ST_DRIVE;
            end
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign circ_in = r_vec;
  assign busy    = r_busy;
  assign done    = r_done;
  assign fitness = r_fit;

endmodule

// File: tb/tb_circuit_evaluator.sv
// Directed bench for circuit_evaluator: two instances (one and two outputs) driven in lockstep.
module tb_circuit_evaluator;

  localparam int N_IN   = 2;
  localparam int SETTLE = 3;
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
  localparam int PER = SETTLE + 2;
`else
  localparam int PER = SETTLE + 1;
`endif
  localparam int DONE_C = 4 * PER + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] target1 = '0;
  logic [7:0] target2 = '0;
  logic [1:0] cin1, cin2;
  logic       cout1;
  logic [1:0] cout2;
  logic       busy1, done1, busy2, done2;
  logic [2:0] fit1;
  logic [3:0] fit2;
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
  logic [2:0] osc1, osc2;
`endif

  logic mode1 = 1'b0;
  logic osc_en = 1'b0;
  logic tgl = 1'b0;

  int errors = 0;
  int checks = 0;

  int         dc1, dc2;
  logic [2:0] f1, f1_end;
  logic [3:0] f2;
  logic       s_busy, s_done;
  logic [1:0] s_cin;
  logic [2:0] s_fit;

  always #5 clk = ~clk;
  always @(posedge clk) tgl <= ~tgl;

  assign cout1 = (osc_en && (cin1 == 2'd2)) ? tgl : (mode1 ? |cin1 : &cin1);
  assign cout2 = {|cin2, &cin2};

  circuit_evaluator #(.N_IN(N_IN), .N_OUT(1), .SETTLE(SETTLE)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target1),
    .circ_in(cin1), .circ_out(cout1), .busy(busy1), .done(done1), .fitness(fit1)
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
    , .osc_count(osc1)
`endif
  );

  circuit_evaluator #(.N_IN(N_IN), .N_OUT(2), .SETTLE(SETTLE)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target2),
    .circ_in(cin2), .circ_out(cout2), .busy(busy2), .done(done2), .fitness(fit2)
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
    , .osc_count(osc2)
`endif
  );

  // Cycle 0 is the cycle start is high; inputs change on the falling edge.
  task automatic run(input logic [3:0] t1, input logic [7:0] t2, input int pulse_c,
                     input int abort_c, input int reset_c, input int snap_c, input int ncyc);
    dc1 = -1; dc2 = -1; f1 = '0; f2 = '0;
    s_busy = 1'bx; s_done = 1'bx; s_cin = 'x; s_fit = 'x;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == snap_c) begin
        s_busy = busy1; s_done = done1; s_cin = cin1; s_fit = fit1;
      end
      if (done1 && dc1 < 0) begin dc1 = c; f1 = fit1; end
      if (done2 && dc2 < 0) begin dc2 = c; f2 = fit2; end
      f1_end = fit1;
      start = (c == 0) || (c == pulse_c);
      if (c == 0) begin
        target1 = t1; target2 = t2;
      end else if (c == pulse_c) begin
        target1 = ~t1; target2 = ~t2;
      end
      abort = (c == abort_c);
      reset = (c == reset_c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b want 0", done1); end
    checks++; if (fit1 !== 3'd0) begin errors++; $display("FAIL reset_fit1 got %0d want 0", fit1); end
    checks++; if (cin1 !== 2'd0) begin errors++; $display("FAIL reset_cin1 got %0d want 0", cin1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b want 0", busy2); end
    checks++; if (fit2 !== 4'd0) begin errors++; $display("FAIL reset_fit2 got %0d want 0", fit2); end
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
    checks++; if (osc1 !== 3'd0) begin errors++; $display("FAIL reset_osc1 got %0d want 0", osc1); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_and();
    mode1 = 1'b0;
    run(4'b1000, 8'b11_10_10_00, -1, -1, -1, PER + 1, DONE_C + 4);
    checks++; if (dc1 !== DONE_C) begin errors++; $display("FAIL and_done_cycle got %0d want %0d", dc1, DONE_C); end
    checks++; if (f1 !== 3'd4) begin errors++; $display("FAIL and_fitness got %0d want 4", f1); end
    checks++; if (dc2 !== DONE_C) begin errors++; $display("FAIL two_out_done_cycle got %0d want %0d", dc2, DONE_C); end
    checks++; if (f2 !== 4'd8) begin errors++; $display("FAIL two_out_fitness got %0d want 8", f2); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL and_busy_vec1 got %b want 1", s_busy); end
    checks++; if (s_cin !== 2'd1) begin errors++; $display("FAIL and_cin_vec1 got %0d want 1", s_cin); end
    checks++; if (f1_end !== 3'd4) begin errors++; $display("FAIL and_fitness_hold got %0d want 4", f1_end); end
  endtask

  task automatic test_and_zero();
    mode1 = 1'b0;
    run(4'b0111, 8'b11_10_10_01, -1, -1, -1, -1, DONE_C + 2);
    checks++; if (f1 !== 3'd0) begin errors++; $display("FAIL and_zero_fitness got %0d want 0", f1); end
    checks++; if (dc1 !== DONE_C) begin errors++; $display("FAIL and_zero_done got %0d want %0d", dc1, DONE_C); end
    checks++; if (f2 !== 4'd7) begin errors++; $display("FAIL two_out_flip_fitness got %0d want 7", f2); end
  endtask

  task automatic test_or_xor();
    mode1 = 1'b1;
    run(4'b0110, 8'b11_10_10_00, -1, -1, -1, -1, DONE_C + 2);
    checks++; if (f1 !== 3'd3) begin errors++; $display("FAIL or_vs_xor_fitness got %0d want 3", f1); end
    checks++; if (dc1 !== DONE_C) begin errors++; $display("FAIL or_vs_xor_done got %0d want %0d", dc1, DONE_C); end
    mode1 = 1'b0;
  endtask

  task automatic test_start_ignored();
    mode1 = 1'b0;
    run(4'b1000, 8'b11_10_10_00, PER + 2, -1, -1, -1, DONE_C + 2);
    checks++; if (dc1 !== DONE_C) begin errors++; $display("FAIL ign_start_done got %0d want %0d", dc1, DONE_C); end
    checks++; if (f1 !== 3'd4) begin errors++; $display("FAIL ign_start_fitness got %0d want 4", f1); end
    checks++; if (f2 !== 4'd8) begin errors++; $display("FAIL ign_start_fitness2 got %0d want 8", f2); end
  endtask

  task automatic test_abort();
    mode1 = 1'b0;
    run(4'b1000, 8'b11_10_10_00, -1, 6, -1, 7, DONE_C + 10);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", s_busy); end
    checks++; if (s_fit !== 3'd0) begin errors++; $display("FAIL abort_fitness got %0d want 0", s_fit); end
    checks++; if (s_cin !== 2'd0) begin errors++; $display("FAIL abort_cin got %0d want 0", s_cin); end
    checks++; if (dc1 !== -1) begin errors++; $display("FAIL abort_no_done got cycle %0d want none", dc1); end
    checks++; if (dc2 !== -1) begin errors++; $display("FAIL abort_no_done2 got cycle %0d want none", dc2); end
  endtask

  task automatic test_reset_mid();
    mode1 = 1'b0;
    run(4'b1000, 8'b11_10_10_00, -1, -1, 9, 10, DONE_C + 10);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", s_busy); end
    checks++; if (s_fit !== 3'd0) begin errors++; $display("FAIL rst_mid_fitness got %0d want 0", s_fit); end
    checks++; if (s_cin !== 2'd0) begin errors++; $display("FAIL rst_mid_cin got %0d want 0", s_cin); end
    checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", s_done); end
    checks++; if (dc1 !== -1) begin errors++; $display("FAIL rst_mid_no_done got cycle %0d want none", dc1); end
  endtask

  task automatic test_back_to_back();
    mode1 = 1'b0;
    run(4'b1000, 8'b11_10_10_00, -1, -1, -1, -1, DONE_C + 1);
    checks++; if (f1 !== 3'd4) begin errors++; $display("FAIL b2b_first_fitness got %0d want 4", f1); end
    mode1 = 1'b1;
    run(4'b0110, 8'b11_10_10_01, -1, -1, -1, -1, DONE_C + 2);
    checks++; if (dc1 !== DONE_C) begin errors++; $display("FAIL b2b_second_done got %0d want %0d", dc1, DONE_C); end
    checks++; if (f1 !== 3'd3) begin errors++; $display("FAIL b2b_second_fitness got %0d want 3", f1); end
    checks++; if (f2 !== 4'd7) begin errors++; $display("FAIL b2b_second_fitness2 got %0d want 7", f2); end
    mode1 = 1'b0;
  endtask

`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
  task automatic test_oscillation();
    mode1 = 1'b0;
    osc_en = 1'b1;
    run(4'b1000, 8'b11_10_10_00, -1, -1, -1, -1, DONE_C + 3);
    checks++; if (dc1 !== 21) begin errors++; $display("FAIL osc_done got %0d want 21", dc1); end
    checks++; if (f1 !== 3'd3) begin errors++; $display("FAIL osc_fitness got %0d want 3", f1); end
    checks++; if (osc1 !== 3'd1) begin errors++; $display("FAIL osc_count got %0d want 1", osc1); end
    checks++; if (osc2 !== 3'd0) begin errors++; $display("FAIL osc_count2 got %0d want 0", osc2); end
    osc_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_and();
    test_and_zero();
    test_or_xor();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef CIRCUIT_EVAL_STABILITY_CHECK_EN
    test_oscillation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
